// File: rtl/johnson_pkg.sv
// Shared encodings and helpers for the
// Johnson / one-hot ring LED counter.
package johnson_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Width of the phase index for a w-bit counter
  function automatic int idx_w(int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Terminal-count clock-enable generator.
// Emits a one-cycle tick every DIVISOR enabled clocks.
module tick_divider #(
  parameter int DIVISOR = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DW-1:0] TERM = DW'(DIVISOR - 1);

  logic [DW-1:0] dcnt;

  assign tick = en && (dcnt == TERM);

  // Count enabled cycles, restart on the terminal count
  always_ff @(posedge clk) begin
    if (rst)
      dcnt <= '0;
    else if (tick)
      dcnt <= '0;
    else if (en)
      dcnt <= dcnt + DW'(1);
  end

endmodule

// File: rtl/johnson_ring_counter.sv
// Johnson / one-hot ring counter with enable divider,
// phase index and self-correction of illegal states.
module johnson_ring_counter
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIVISOR = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      dir,
  output logic [WIDTH-1:0]          q,
  output logic [idx_w(WIDTH)-1:0]   idx,
  output logic                      step,
  output logic                      wrap,
  output logic                      illegal
);

  localparam int IW = idx_w(WIDTH);
  localparam logic [WIDTH-1:0] RING_SEED =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic             tick;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] nq;

  tick_divider #(.DIVISOR(DIVISOR)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Johnson legal: at most one boundary between
  // adjacent bits (ones-then-zeros or zeros-then-ones)
  function automatic logic legal_j(logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] d;
    d = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    return (d & (d - (WIDTH-1)'(1))) == '0;
  endfunction

  function automatic logic legal_r(logic [WIDTH-1:0] v);
    return (v != '0) &&
           ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Sequence position of a legal state
  function automatic logic [IW-1:0] pos_of(
    logic [WIDTH-1:0] v,
    logic             m
  );
    int pc;
    int p;
    pc = 0;
    p  = 0;
    for (int i = 0; i < WIDTH; i++)
      pc += int'(v[i]);
    if (m == MODE_RING) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) p = WIDTH - 1 - i;
    end else if (v[WIDTH-1]) begin
      p = pc;
    end else if (pc != 0) begin
      p = 2 * WIDTH - pc;
    end
    return IW'(p);
  endfunction

  assign seed    = (mode == MODE_RING) ? RING_SEED : '0;
  assign illegal = (mode == MODE_RING) ? !legal_r(q)
                                       : !legal_j(q);

  // Next state: reseed when illegal, else shift
  always_comb begin
    nq = q;
    if (illegal) begin
      nq = seed;
    end else begin
      unique case ({mode, dir})
        {MODE_JOHNSON, DIR_FWD}:
          nq = {~q[0], q[WIDTH-1:1]};
        {MODE_JOHNSON, DIR_REV}:
          nq = {q[WIDTH-2:0], ~q[WIDTH-1]};
        {MODE_RING, DIR_FWD}:
          nq = {q[0], q[WIDTH-1:1]};
        {MODE_RING, DIR_REV}:
          nq = {q[WIDTH-2:0], q[WIDTH-1]};
        default:
          nq = q;
      endcase
    end
  end

  // State, phase index and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      idx  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      step <= tick;
      wrap <= tick && (nq == seed);
      if (tick) begin
        q   <= nq;
        idx <= pos_of(nq, mode);
      end
    end
  end

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Randomised bench for johnson_ring_counter:
// three widths checked against a sequence-position model.
module tb_johnson_ring_counter;

  logic clk = 1'b0;
  logic rst, en, mode, dir;

  logic [3:0] q4;
  logic [2:0] idx4;
  logic       step4, wrap4, ill4;
  logic [1:0] q2;
  logic [1:0] idx2;
  logic       step2, wrap2, ill2;
  logic [6:0] q7;
  logic [3:0] idx7;
  logic       step7, wrap7, ill7;

  always #5 clk = ~clk;

  johnson_ring_counter #(.WIDTH(4), .DIVISOR(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .q(q4), .idx(idx4), .step(step4), .wrap(wrap4),
    .illegal(ill4)
  );

  johnson_ring_counter #(.WIDTH(2), .DIVISOR(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .q(q2), .idx(idx2), .step(step2), .wrap(wrap2),
    .illegal(ill2)
  );

  johnson_ring_counter #(.WIDTH(7), .DIVISOR(3)) dut7 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .q(q7), .idx(idx7), .step(step7), .wrap(wrap7),
    .illegal(ill7)
  );

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  int W[3] = '{4, 2, 7};
  int D[3] = '{4, 1, 3};

  logic [31:0] mq[3];
  int          midx[3];
  int          mdc[3];
  bit          mstep[3];
  bit          mwrap[3];

  // State at sequence position k, built from the
  // description of each sequence rather than shifts
  function automatic logic [31:0] pat(int w, bit m, int k);
    logic [31:0] v;
    v = '0;
    if (m) begin
      v[w-1-k] = 1'b1;
    end else if (k <= w) begin
      for (int i = 0; i < k; i++) v[w-1-i] = 1'b1;
    end else begin
      for (int i = 0; i < 2*w-k; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int seqlen(int w, bit m);
    return m ? w : 2 * w;
  endfunction

  function automatic int posof(int w, bit m, logic [31:0] v);
    for (int k = 0; k < seqlen(w, m); k++)
      if (pat(w, m, k) == v) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i] = '0; midx[i] = 0; mdc[i] = 0;
        mstep[i] = 0; mwrap[i] = 0;
      end else begin
        mstep[i] = 0; mwrap[i] = 0;
        if (en) begin
          if (mdc[i] == D[i] - 1) begin
            int p, L, np;
            mdc[i] = 0;
            L = seqlen(W[i], mode);
            p = posof(W[i], mode, mq[i]);
            if (p < 0) np = 0;
            else if (dir) np = (p + L - 1) % L;
            else np = (p + 1) % L;
            mq[i] = pat(W[i], mode, np);
            midx[i] = np;
            mstep[i] = 1;
            mwrap[i] = (np == 0);
          end else begin
            mdc[i] = mdc[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d act=%h exp=%h",
               nm, cyc_n, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] aq, ai;
    logic        as, aw, al;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          aq = 32'(q4); ai = 32'(idx4);
          as = step4; aw = wrap4; al = ill4;
        end
        1: begin
          aq = 32'(q2); ai = 32'(idx2);
          as = step2; aw = wrap2; al = ill2;
        end
        default: begin
          aq = 32'(q7); ai = 32'(idx7);
          as = step7; aw = wrap7; al = ill7;
        end
      endcase
      chk($sformatf("w%0d_q", W[i]), aq, mq[i]);
      chk($sformatf("w%0d_idx", W[i]), ai, 32'(midx[i]));
      chk($sformatf("w%0d_step", W[i]), 32'(as),
          32'(mstep[i]));
      chk($sformatf("w%0d_wrap", W[i]), 32'(aw),
          32'(mwrap[i]));
      chk($sformatf("w%0d_illegal", W[i]), 32'(al),
          32'(posof(W[i], mode, mq[i]) < 0));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    check_all();
  endtask

  logic [3:0] jtbl[8] = '{4'b0000, 4'b1000, 4'b1100,
    4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0;
    repeat (2) cyc();
    chk("reset_q4", 32'(q4), 32'h0);
    chk("reset_idx4", 32'(idx4), 32'h0);

    // Johnson forward, one advance per 4 enabled edges
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      repeat (4) cyc();
      chk("dir_q4", 32'(q4), 32'(jtbl[k % 8]));
      chk("dir_idx4", 32'(idx4), 32'(k % 8));
      chk("dir_wrap4", 32'(wrap4), 32'(k == 8));
    end

    // Ring from reset: illegal zero, then seed
    rst = 1'b1; mode = 1'b1;
    cyc();
    chk("ring_rst_ill2", 32'(ill2), 32'h1);
    rst = 1'b0;
    cyc();
    chk("ring_seed_q2", 32'(q2), 32'h2);
    chk("ring_seed_step2", 32'(step2), 32'h1);
    chk("ring_seed_wrap2", 32'(wrap2), 32'h1);
    cyc();
    chk("ring_next_q2", 32'(q2), 32'h1);

    // Johnson to ring switch from a two-ones state
    rst = 1'b1; mode = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("sw_q7", 32'(q7), 32'h60);
    mode = 1'b1;
    cyc();
    chk("sw_ill7", 32'(ill7), 32'h1);
    cyc();
    chk("sw_hold_q7", 32'(q7), 32'h60);
    cyc();
    chk("sw_seed_q7", 32'(q7), 32'h40);
    chk("sw_wrap7", 32'(wrap7), 32'h1);
    chk("sw_idx7", 32'(idx7), 32'h0);

    // Randomised mix of enable, mode, direction, reset
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom % 8) != 0;
      rst = ($urandom % 200) == 0;
      if ($urandom % 50 == 0) mode = ~mode;
      if ($urandom % 20 == 0) dir = ~dir;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
